imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Parametrised instruction memory: DEPTH x DATA_W.
- Independent fetch read port for the core.
- Built-in byte-stream loader: assembles UART bytes into words and writes them at auto-incrementing addresses.
- Sits between the UART receiver and the CPU fetch stage; the CPU stays halted while `load_busy` is high.

Parameters:
- DATA_W, 24, instruction width in bits; must be a multiple of 8.
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W.
- BOOT_WORD, 24'hF000AA, initial content of address 0 (HALT); all other words initialise to 0.
- (derived) BPW = DATA_W/8, bytes per word.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- fetch_addr  in  ADDR_W  fetch read address.
- fetch_data  out  DATA_W  registered read data.
- load_start  in  1  one-cycle pulse that begins a load.
- load_base  in  ADDR_W  first write address, sampled on load_start.
- load_len  in  ADDR_W+1  number of words to load, sampled on load_start.
- rx_valid  in  1  byte available.
- rx_data  in  8  byte value.
- rx_ready  out  1  loader accepts a byte this cycle.
- load_busy  out  1  load in progress.
- data_ack  out  1  one-cycle pulse per word written.
- load_done  out  1  one-cycle pulse when a load completes.
- word_count  out  ADDR_W+1  words written in the current/last load.

Behaviour:
- Reset values: fetch_data=0, rx_ready=0, load_busy=0, data_ack=0, load_done=0, word_count=0, FSM=IDLE, byte counter=0. Memory contents are not cleared by reset.
- Fetch: fetch_data <= mem[fetch_addr] every cycle, latency 1.
  - Read and write on the same address in the same cycle returns OLD data.
  - Fetch is unaffected by rst except that fetch_data is forced to 0 during the rst cycle.
- A byte transfers when rx_valid && rx_ready; bytes arrive MSB first (big-endian).
- IDLE:
  - rx_ready=0.
  - load_start with load_len=0 -> load_done pulse next cycle, word_count=0, stay IDLE.
  - load_start with load_len>0 -> wptr<=load_base, remaining<=load_len, word_count<=0, go COLLECT.
- COLLECT:
  - load_busy=1, rx_ready=1.
  - Each transfer shifts the byte into the assembly register and increments bcnt.
  - On the BPW-th byte -> go WRITE.
- WRITE (one cycle):
  - rx_ready=0.
  - mem[wptr]<=assembled word; data_ack=1 this cycle.
  - wptr<=wptr+1, wrapping DEPTH-1 -> 0.
  - word_count+=1, remaining-=1, bcnt<=0.
  - remaining becomes 0 -> load_done=1 next cycle, go IDLE; else go COLLECT.
- load_start while busy is ignored.
- rx_valid while IDLE is not consumed (rx_ready=0).
- rst mid-load:
  - FSM returns to IDLE and the partial word is discarded.
  - Words already written remain in memory; word_count clears to 0.
- load_len > DEPTH is legal: writes wrap and overwrite earlier words.
- Throughput: BPW+1 cycles per word minimum.

Optional Feature:
- IMEM_CHECKSUM_EN defined:
  - Adds output port `load_csum[7:0]`: 8-bit modulo-256 sum of all bytes accepted in the current load.
  - Cleared on rst and on an accepted load_start; holds its value after load_done.
- Undefined: the port and its adder are absent; behaviour is otherwise identical.

Decomposition:
- Shared package `imem_pkg`:
  - FSM state enum (IDLE, COLLECT, WRITE).
  - Default DATA_W/ADDR_W constants.
  - BOOT_WORD HALT constant, shared with the core decoder.
- One sub-module is natural: `imem_byte_packer`. It owns bcnt, the shift register and the word-complete strobe. The top level keeps the FSM, wptr and the memory array.

Test Plan:
- Reset, then fetch_addr=0 -> fetch_data=24'hF000AA one cycle later; rx_ready=0, load_busy=0.
- load_start, base=8'h10, len=2; bytes 12 34 56 AB CD EF -> data_ack pulses twice; mem[10]=123456, mem[11]=ABCDEF; load_done one cycle after the 2nd ack; word_count=2.
- base=8'hFF, len=2; bytes 01 02 03 04 05 06 -> mem[FF]=010203, mem[00]=040506 (wrap; BOOT_WORD overwritten).
- len=0 -> load_done next cycle, no data_ack, load_busy never 1.
- Assert rst after 2 bytes of a word -> IDLE, word_count=0, target word unchanged. New load, bytes AA BB CC -> written correctly (stale bytes discarded).
- Fetch addr 5 in the same cycle the loader writes 0x777777 to addr 5 -> old value returned; next cycle returns 777777. With IMEM_CHECKSUM_EN and bytes 12 34 56 -> load_csum=8'h9C.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory loader and the core decoder:
// default geometry, the HALT boot word and the loader FSM state encoding.
package imem_pkg;

  localparam int DEF_DATA_W = 24;
  localparam int DEF_ADDR_W = 8;

  localparam logic [23:0] BOOT_WORD_HALT = 24'hF000AA;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE
  } load_state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Assembles a big-endian byte stream into DATA_W-bit words and flags the
// byte that completes each word.
module imem_byte_packer #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word,
  output logic              word_done
);

  localparam int BPW = DATA_W / 8;
  localparam int CW  = $clog2(BPW + 1);

  logic [CW-1:0] bcnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      bcnt <= '0;
    end else if (shift_en) begin
      bcnt <= bcnt + 1'b1;
    end
  end

  // Earlier bytes move toward the MSB, so the first byte received ends up on top.
  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
    end else if (shift_en) begin
      word <= DATA_W'({word, byte_in});
    end
  end

  assign word_done = shift_en && (bcnt == CW'(BPW - 1));

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with a registered fetch port and a UART byte-stream loader.
// Optional macro IMEM_CHECKSUM_EN adds the load_csum byte-sum output.
module imem_loader
  import imem_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] BOOT_WORD = DATA_W'(BOOT_WORD_HALT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              load_busy,
  output logic              data_ack,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count
`ifdef IMEM_CHECKSUM_EN
  ,
  output logic [7:0]        load_csum
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  load_state_t state, state_next;

  logic [DATA_W-1:0] mem [DEPTH] = '{0: BOOT_WORD, default: '0};
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W:0]   remaining;
  logic [DATA_W-1:0] packed_word;
  logic              word_done;
  logic              xfer;

  assign xfer = rx_valid && rx_ready;

  imem_byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (state != COLLECT),
    .shift_en  (xfer),
    .byte_in   (rx_data),
    .word      (packed_word),
    .word_done (word_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    rx_ready   = 1'b0;
    load_busy  = 1'b0;
    data_ack   = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_start && (load_len != '0)) state_next = COLLECT;
      end
      COLLECT: begin
        rx_ready  = 1'b1;
        load_busy = 1'b1;
        if (word_done) state_next = WRITE;
      end
      WRITE: begin
        load_busy  = 1'b1;
        data_ack   = 1'b1;
        state_next = (remaining == 1) ? IDLE : COLLECT;
      end
      default: state_next = IDLE;
    endcase
  end

  // load_start only takes effect from IDLE; a zero-length load just reports done.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      remaining  <= '0;
      word_count <= '0;
      load_done  <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            word_count <= '0;
            if (load_len == '0) begin
              load_done <= 1'b1;
            end else begin
              wptr      <= load_base;
              remaining <= load_len;
            end
          end
        end
        WRITE: begin
          wptr       <= wptr + 1'b1;
          word_count <= word_count + 1'b1;
          remaining  <= remaining - 1'b1;
          if (remaining == 1) load_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == WRITE) mem[wptr] <= packed_word;
  end

  // Reads sample the array before the same-edge write lands, giving old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_data <= '0;
    end else begin
      fetch_data <= mem[fetch_addr];
    end
  end

`ifdef IMEM_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      load_csum <= '0;
    end else if ((state == IDLE) && load_start) begin
      load_csum <= '0;
    end else if (xfer) begin
      load_csum <= load_csum + rx_data;
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, loads, wrap, zero length, reset
// mid-load, read-during-write and (with IMEM_CHECKSUM_EN) the checksum.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  fetch_addr = '0;
  logic [23:0] fetch_data;
  logic        load_start = 1'b0;
  logic [7:0]  load_base = '0;
  logic [8:0]  load_len = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready;
  logic        load_busy;
  logic        data_ack;
  logic        load_done;
  logic [8:0]  word_count;
`ifdef IMEM_CHECKSUM_EN
  logic [7:0]  load_csum;
`endif

  int n_vec = 0;
  int n_err = 0;

  int cyc = 0;
  int ack_cnt = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int last_ack_cyc = 0;
  int done_cyc = 0;

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .load_start (load_start),
    .load_base  (load_base),
    .load_len   (load_len),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .load_busy  (load_busy),
    .data_ack   (data_ack),
    .load_done  (load_done),
    .word_count (word_count)
`ifdef IMEM_CHECKSUM_EN
    ,
    .load_csum  (load_csum)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (data_ack) begin
      ack_cnt = ack_cnt + 1;
      last_ack_cyc = cyc;
    end
    if (load_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (load_busy) busy_cnt = busy_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [7:0] base, input logic [8:0] len);
    load_start = 1'b1;
    load_base  = base;
    load_len   = len;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!rx_ready) begin
      n_err++;
      $display("[TB] FAIL rx_ready_timeout byte=%h waited %0d cycles", b, waited);
    end
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic read_mem(input logic [7:0] a, output logic [23:0] d);
    fetch_addr = a;
    tick();
    d = fetch_data;
  endtask

  task automatic test_reset();
    logic [23:0] d;
    rst = 1'b1;
    fetch_addr = 8'h00;
    tick();
    n_vec++;
    if (fetch_data !== 24'h0) begin
      n_err++;
      $display("[TB] FAIL reset_fetch_zero got %h want 000000", fetch_data);
    end
    rst = 1'b0;
    read_mem(8'h00, d);
    n_vec++;
    if (d !== 24'hF000AA) begin
      n_err++;
      $display("[TB] FAIL boot_word got %h want F000AA", d);
    end
    n_vec++;
    if ({rx_ready, load_busy, data_ack, load_done} !== 4'b0000 || word_count !== 9'd0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs got rdy/busy/ack/done=%b%b%b%b wc=%0d want 0000 wc=0",
               rx_ready, load_busy, data_ack, load_done, word_count);
    end
  endtask

  task automatic test_basic_load();
    logic [23:0] d;
    int a0, d0;
    a0 = ack_cnt;
    d0 = done_cnt;
    start_load(8'h10, 9'd2);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF);
    tick(); tick(); tick();
    n_vec++;
    if (ack_cnt - a0 !== 2) begin
      n_err++;
      $display("[TB] FAIL basic_ack_count got %0d want 2", ack_cnt - a0);
    end
    n_vec++;
    if (done_cnt - d0 !== 1 || done_cyc !== last_ack_cyc + 1) begin
      n_err++;
      $display("[TB] FAIL basic_done_timing got done=%0d at %0d want 1 at %0d",
               done_cnt - d0, done_cyc, last_ack_cyc + 1);
    end
    n_vec++;
    if (word_count !== 9'd2 || load_busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL basic_wc got wc=%0d busy=%b want wc=2 busy=0", word_count, load_busy);
    end
    read_mem(8'h10, d);
    n_vec++;
    if (d !== 24'h123456) begin
      n_err++;
      $display("[TB] FAIL basic_mem10 got %h want 123456", d);
    end
    read_mem(8'h11, d);
    n_vec++;
    if (d !== 24'hABCDEF) begin
      n_err++;
      $display("[TB] FAIL basic_mem11 got %h want ABCDEF", d);
    end
  endtask

  task automatic test_wrap();
    logic [23:0] d;
    start_load(8'hFF, 9'd2);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h04); send_byte(8'h05); send_byte(8'h06);
    tick(); tick(); tick();
    read_mem(8'hFF, d);
    n_vec++;
    if (d !== 24'h010203) begin
      n_err++;
      $display("[TB] FAIL wrap_memFF got %h want 010203", d);
    end
    read_mem(8'h00, d);
    n_vec++;
    if (d !== 24'h040506) begin
      n_err++;
      $display("[TB] FAIL wrap_mem00 got %h want 040506", d);
    end
    n_vec++;
    if (word_count !== 9'd2) begin
      n_err++;
      $display("[TB] FAIL wrap_wc got %0d want 2", word_count);
    end
  endtask

  task automatic test_zero_len();
    int a0, b0;
    a0 = ack_cnt;
    b0 = busy_cnt;
    start_load(8'h40, 9'd0);
    n_vec++;
    if (load_done !== 1'b1 || word_count !== 9'd0) begin
      n_err++;
      $display("[TB] FAIL zero_done got done=%b wc=%0d want done=1 wc=0", load_done, word_count);
    end
    tick();
    n_vec++;
    if (load_done !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL zero_done_pulse got %b want 0", load_done);
    end
    tick(); tick();
    n_vec++;
    if (ack_cnt !== a0 || busy_cnt !== b0) begin
      n_err++;
      $display("[TB] FAIL zero_no_activity got acks=%0d busy=%0d want 0 0",
               ack_cnt - a0, busy_cnt - b0);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [23:0] d;
    int a0;
    rx_valid = 1'b1;
    rx_data  = 8'h99;
    tick(); tick();
    n_vec++;
    if (rx_ready !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL idle_rx_ready got %b want 0", rx_ready);
    end
    rx_valid = 1'b0;
    start_load(8'h20, 9'd1);
    send_byte(8'h11); send_byte(8'h22);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    n_vec++;
    if (word_count !== 9'd0 || load_busy !== 1'b0 || rx_ready !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL midrst_state got wc=%0d busy=%b rdy=%b want 0 0 0",
               word_count, load_busy, rx_ready);
    end
    read_mem(8'h20, d);
    n_vec++;
    if (d !== 24'h000000) begin
      n_err++;
      $display("[TB] FAIL midrst_target got %h want 000000", d);
    end
    read_mem(8'h10, d);
    n_vec++;
    if (d !== 24'h123456) begin
      n_err++;
      $display("[TB] FAIL midrst_keep got %h want 123456", d);
    end
    a0 = ack_cnt;
    start_load(8'h20, 9'd1);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    tick(); tick();
    read_mem(8'h20, d);
    n_vec++;
    if (d !== 24'hAABBCC || ack_cnt - a0 !== 1) begin
      n_err++;
      $display("[TB] FAIL midrst_reload got %h acks=%0d want AABBCC acks=1", d, ack_cnt - a0);
    end
  endtask

  task automatic test_read_during_write();
    fetch_addr = 8'h05;
    start_load(8'h05, 9'd1);
    send_byte(8'h77); send_byte(8'h77); send_byte(8'h77);
    n_vec++;
    if (data_ack !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL rdw_ack got %b want 1", data_ack);
    end
    tick();
    n_vec++;
    if (fetch_data !== 24'h000000) begin
      n_err++;
      $display("[TB] FAIL rdw_old got %h want 000000", fetch_data);
    end
    tick();
    n_vec++;
    if (fetch_data !== 24'h777777) begin
      n_err++;
      $display("[TB] FAIL rdw_new got %h want 777777", fetch_data);
    end
  endtask

`ifdef IMEM_CHECKSUM_EN
  task automatic test_checksum();
    start_load(8'h30, 9'd1);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    tick(); tick(); tick();
    n_vec++;
    if (load_csum !== 8'h9C) begin
      n_err++;
      $display("[TB] FAIL csum got %h want 9C", load_csum);
    end
  endtask
`endif

  initial begin
    tick();
    test_reset();
    test_basic_load();
    test_wrap();
    test_zero_len();
    test_reset_mid_load();
    test_read_during_write();
`ifdef IMEM_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
